// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - unified memory arbiter between the CPU port and the loader/debug port
//
// Purpose:
//   Shares one instruction/data memory between the multicycle CPU (MemRead/MemWrite)
//   and a loader/debug port. One access is in flight at a time. The CPU is held off
//   with cpu_stall. The loader is guaranteed a grant after losing MAX_WAIT arbitrations.
//
// Ports:
//   clk, reset                 system clock (rising edge), asynchronous active-high reset
//   cpu_rd, cpu_wr             CPU request; both high is treated as a write
//   cpu_addr, cpu_wdata        CPU byte address and write data
//   cpu_rdata                  registered CPU read data, valid while cpu_stall is low in CPU_RESP
//   cpu_stall                  CPU must hold its state and request while high
//   ldr_req, ldr_we            loader request (held until ldr_ack), write(1)/read(0)
//   ldr_addr, ldr_wdata        loader address and write data
//   ldr_rdata, ldr_ack         registered loader read data, one-cycle completion pulse
//   mem_en, mem_we             one-cycle access strobe and write qualifier to memory
//   mem_addr, mem_wdata        registered memory address and write data
//   mem_rdata                  memory read data, valid MEM_LAT cycles after mem_en
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int LW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    CPU_WAIT,
    CPU_RESP,
    LDR_WAIT,
    LDR_RESP
  } state_t;

  state_t        state;
  logic [LW-1:0] lat_cnt;
  logic [WW-1:0] wcnt;
  logic          cpu_req;
  logic          ldr_win;

  assign cpu_req = cpu_rd | cpu_wr;

  // Loader wins when the CPU is quiet, or when it has already lost MAX_WAIT times in a row.
  assign ldr_win = ldr_req & (~cpu_req | (wcnt == WW'(MAX_WAIT)));

  // Combinational so the control FSM freezes in the same cycle it raises MemRead/MemWrite.
  assign cpu_stall = ~reset & cpu_req & (state != CPU_RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      wcnt      <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
      ldr_ack   <= 1'b0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      mem_en  <= 1'b0;
      ldr_ack <= 1'b0;
      if (!ldr_req) begin
        wcnt <= '0;
      end

      case (state)
        IDLE: begin
          if (ldr_win) begin
            mem_en    <= 1'b1;
            mem_we    <= ldr_we;
            mem_addr  <= ldr_addr;
            mem_wdata <= ldr_wdata;
            lat_cnt   <= LW'(MEM_LAT);
            wcnt      <= '0;
            state     <= LDR_WAIT;
          end else if (cpu_req) begin
            mem_en    <= 1'b1;
            mem_we    <= cpu_wr;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            lat_cnt   <= LW'(MEM_LAT);
            state     <= CPU_WAIT;
            if (ldr_req && (wcnt != WW'(MAX_WAIT))) begin
              wcnt <= wcnt + WW'(1);
            end
          end
        end

        // Counter reaches zero exactly MEM_LAT cycles after the issue cycle, when mem_rdata is valid.
        CPU_WAIT: begin
          if (lat_cnt == '0) begin
            cpu_rdata <= mem_rdata;
            state     <= CPU_RESP;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end

        LDR_WAIT: begin
          if (lat_cnt == '0) begin
            ldr_rdata <= mem_rdata;
            ldr_ack   <= 1'b1;
            state     <= LDR_RESP;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end

        // No grant from a response state: requesters get one cycle to update their request.
        CPU_RESP: state <= IDLE;
        LDR_RESP: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule
